// File: rtl/bayer_demosaic_2x2.sv
// 2x2 Bayer window to RGB pixel: frame-sync FSM, two-stage pipeline, optional 2:1 decimation.
// Define GRAY_OUT_EN to add the out_gray luma port.
module bayer_demosaic_2x2 #(
  parameter int unsigned N     = 8,
  parameter int unsigned CNT_W = 24
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [N-1:0]     in_data00,
  input  logic [N-1:0]     in_data01,
  input  logic [N-1:0]     in_data10,
  input  logic [N-1:0]     in_data11,
  input  logic [11:0]      in_x,
  input  logic [11:0]      in_y,
  input  logic             in_done,
  input  logic             decimate,
  input  logic [1:0]       bayer_phase,
  output logic             out_valid,
  output logic [N-1:0]     out_red,
  output logic [N-1:0]     out_green,
  output logic [N-1:0]     out_blue,
  output logic [11:0]      out_x,
  output logic [11:0]      out_y,
  output logic             out_done,
`ifdef GRAY_OUT_EN
  output logic [N-1:0]     out_gray,
`endif
  output logic [CNT_W-1:0] pixel_count
);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e      state_q;
  logic        dec_q;
  logic [1:0]  phase_q;

  logic        origin, accept, py, px;
  logic [N-1:0] r_sel, b_sel, g_a, g_b;
  logic [N:0]   g_sum;
  logic [11:0]  x_next, y_next;

  logic         s1_valid_q, done1_q;
  logic [N-1:0] s1_r_q, s1_b_q;
  logic [N:0]   s1_gsum_q;
  logic [11:0]  s1_x_q, s1_y_q;
  logic [N-1:0] s1_g;

  assign s1_g = s1_gsum_q[N:1];

  always_comb begin
    origin = in_valid && (in_x == 12'd0) && (in_y == 12'd0);
    // Row/column 0 windows straddle the frame edge and carry stale line-buffer data.
    accept = (state_q == StActive) && in_valid && (in_x != 12'd0) && (in_y != 12'd0) &&
             (!dec_q || (in_x[0] && in_y[0]));
    py = ~in_y[0] ^ phase_q[1];
    px = ~in_x[0] ^ phase_q[0];
    r_sel = in_data01;
    b_sel = in_data10;
    g_a   = in_data00;
    g_b   = in_data11;
    unique case ({py, px})
      2'b00: begin r_sel = in_data01; b_sel = in_data10; g_a = in_data00; g_b = in_data11; end
      2'b01: begin r_sel = in_data00; b_sel = in_data11; g_a = in_data01; g_b = in_data10; end
      2'b10: begin r_sel = in_data11; b_sel = in_data00; g_a = in_data01; g_b = in_data10; end
      2'b11: begin r_sel = in_data10; b_sel = in_data01; g_a = in_data00; g_b = in_data11; end
      default: ;
    endcase
    g_sum  = {1'b0, g_a} + {1'b0, g_b};
    x_next = dec_q ? (in_x >> 1) : (in_x - 12'd1);
    y_next = dec_q ? (in_y >> 1) : (in_y - 12'd1);
  end

  // Frame-sync FSM, per-frame configuration latch and emitted-pixel counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      dec_q       <= 1'b0;
      phase_q     <= 2'b00;
      pixel_count <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (origin) begin
            state_q <= StActive;
            dec_q   <= decimate;
            phase_q <= bayer_phase;
          end
        end
        StActive: begin
          if (in_done) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
      if ((state_q == StIdle) && origin) begin
        pixel_count <= '0;
      end else if (s1_valid_q && !(&pixel_count)) begin
        pixel_count <= pixel_count + 1'b1;
      end
    end
  end

  // Stage 1: channel select and green sum. Stage 2: registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      done1_q    <= 1'b0;
      s1_r_q     <= '0;
      s1_b_q     <= '0;
      s1_gsum_q  <= '0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      out_valid  <= 1'b0;
      out_done   <= 1'b0;
      out_red    <= '0;
      out_green  <= '0;
      out_blue   <= '0;
      out_x      <= '0;
      out_y      <= '0;
`ifdef GRAY_OUT_EN
      out_gray   <= '0;
`endif
    end else begin
      s1_valid_q <= accept;
      done1_q    <= in_done;
      if (accept) begin
        s1_r_q    <= r_sel;
        s1_b_q    <= b_sel;
        s1_gsum_q <= g_sum;
        s1_x_q    <= x_next;
        s1_y_q    <= y_next;
      end
      out_valid <= s1_valid_q;
      out_done  <= done1_q;
      if (s1_valid_q) begin
        out_red   <= s1_r_q;
        out_green <= s1_g;
        out_blue  <= s1_b_q;
        out_x     <= s1_x_q;
        out_y     <= s1_y_q;
`ifdef GRAY_OUT_EN
        out_gray  <= 10'(({2'b00, s1_r_q} + {1'b0, s1_g, 1'b0} + {2'b00, s1_b_q}) >> 2);
`endif
      end
    end
  end

endmodule

// File: tb/tb_bayer_demosaic_2x2.sv
// Directed self-checking bench for bayer_demosaic_2x2.
module tb_bayer_demosaic_2x2;

  logic        clock, reset, in_valid, in_done, decimate;
  logic [7:0]  in_data00, in_data01, in_data10, in_data11;
  logic [11:0] in_x, in_y;
  logic [1:0]  bayer_phase;
  logic        out_valid, out_done;
  logic [7:0]  out_red, out_green, out_blue;
  logic [11:0] out_x, out_y;
  logic [23:0] pixel_count;
`ifdef GRAY_OUT_EN
  logic [7:0]  out_gray;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  bayer_demosaic_2x2 #(.N(8), .CNT_W(24)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data00   (in_data00),
    .in_data01   (in_data01),
    .in_data10   (in_data10),
    .in_data11   (in_data11),
    .in_x        (in_x),
    .in_y        (in_y),
    .in_done     (in_done),
    .decimate    (decimate),
    .bayer_phase (bayer_phase),
    .out_valid   (out_valid),
    .out_red     (out_red),
    .out_green   (out_green),
    .out_blue    (out_blue),
    .out_x       (out_x),
    .out_y       (out_y),
    .out_done    (out_done),
`ifdef GRAY_OUT_EN
    .out_gray    (out_gray),
`endif
    .pixel_count (pixel_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic win(input logic [11:0] x, input logic [11:0] y, input logic [7:0] a,
                     input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    in_valid  = 1'b1;
    in_x      = x;
    in_y      = y;
    in_data00 = a;
    in_data01 = b;
    in_data10 = c;
    in_data11 = d;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  int k, dn;
  logic [11:0] exp_x [4];
  logic [11:0] exp_y [4];

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_done = 1'b0; decimate = 1'b0; bayer_phase = 2'b00;
    in_x = '0; in_y = '0; in_data00 = '0; in_data01 = '0; in_data10 = '0; in_data11 = '0;
    tick; tick;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_red", 32'(out_red), 0);
    chk("rst_x", 32'(out_x), 0);
    chk("rst_done", 32'(out_done), 0);
    chk("rst_count", 32'(pixel_count), 0);
    reset = 1'b0;

    // Windows before any origin are dropped
    for (int i = 0; i < 5; i++) begin
      if (i < 3) win(12'(i + 1), 12'd1, 8'd1, 8'd2, 8'd3, 8'd4);
      else in_valid = 1'b0;
      tick;
      chk("pre_origin_drop", 32'(out_valid), 0);
    end

    // Test 1: phase 00, full resolution
    win(12'd0, 12'd0, 8'd1, 8'd2, 8'd3, 8'd4); tick;
    chk("t1_origin_no_out", 32'(out_valid), 0);
    win(12'd1, 12'd1, 8'd10, 8'd200, 8'd50, 8'd30); tick;
    chk("t1_lat1", 32'(out_valid), 0);
    in_valid = 1'b0; tick;
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_red", 32'(out_red), 200);
    chk("t1_green", 32'(out_green), 20);
    chk("t1_blue", 32'(out_blue), 50);
    chk("t1_x", 32'(out_x), 0);
    chk("t1_y", 32'(out_y), 0);
    chk("t1_count", 32'(pixel_count), 1);
    tick;
    chk("t1_pulse", 32'(out_valid), 0);
    chk("t1_hold", 32'(out_red), 200);

    // Mid-frame phase/decimate changes are ignored
    bayer_phase = 2'b01; decimate = 1'b1;
    win(12'd2, 12'd2, 8'd10, 8'd200, 8'd50, 8'd30); tick;
    in_valid = 1'b0; tick;
    chk("latch_valid", 32'(out_valid), 1);
    chk("latch_red", 32'(out_red), 50);
    chk("latch_blue", 32'(out_blue), 200);
    chk("latch_green", 32'(out_green), 20);
    chk("latch_x", 32'(out_x), 1);
    chk("latch_count", 32'(pixel_count), 2);

    // End of frame: out_done two clocks after in_done
    in_done = 1'b1; tick;
    in_done = 1'b0;
    chk("done_d1", 32'(out_done), 0);
    tick;
    chk("done_d2", 32'(out_done), 1);
    tick;
    chk("done_pulse", 32'(out_done), 0);

    // Back in IDLE: non-origin windows dropped
    win(12'd1, 12'd1, 8'd10, 8'd200, 8'd50, 8'd30); tick;
    in_valid = 1'b0; tick;
    chk("idle_drop", 32'(out_valid), 0);

    // Test 2: phase 01, back-to-back windows, green saturation
    decimate = 1'b0; bayer_phase = 2'b01;
    win(12'd0, 12'd0, 8'd0, 8'd0, 8'd0, 8'd0); tick;
    chk("t2_count_clr", 32'(pixel_count), 0);
    win(12'd1, 12'd1, 8'd10, 8'd200, 8'd50, 8'd30); tick;
    win(12'd1, 12'd1, 8'd0, 8'd255, 8'd255, 8'd0); tick;
    chk("t2_valid", 32'(out_valid), 1);
    chk("t2_red", 32'(out_red), 10);
    chk("t2_green", 32'(out_green), 125);
    chk("t2_blue", 32'(out_blue), 30);
    in_valid = 1'b0; tick;
    chk("t2b_valid", 32'(out_valid), 1);
    chk("t2b_green", 32'(out_green), 255);
    chk("t2b_red", 32'(out_red), 0);
    chk("t2_count", 32'(pixel_count), 2);
    in_done = 1'b1; tick;
    in_done = 1'b0; tick; tick;

    // Test 3: decimated 4x4 frame, in_done coincident with the last window
    decimate = 1'b1; bayer_phase = 2'b00;
    exp_x[0] = 12'd0; exp_y[0] = 12'd0;
    exp_x[1] = 12'd1; exp_y[1] = 12'd0;
    exp_x[2] = 12'd0; exp_y[2] = 12'd1;
    exp_x[3] = 12'd1; exp_y[3] = 12'd1;
    k = 0; dn = 0;
    for (int i = 0; i < 22; i++) begin
      if (i < 16) begin
        win(12'(i % 4), 12'(i / 4), 8'd10, 8'd200, 8'd50, 8'd30);
        in_done = (i == 15);
      end else begin
        in_valid = 1'b0;
        in_done  = 1'b0;
      end
      tick;
      if (out_valid) begin
        if (k < 4) begin
          chk("t3_x", 32'(out_x), 32'(exp_x[k]));
          chk("t3_y", 32'(out_y), 32'(exp_y[k]));
        end
        k++;
      end
      if (out_done) dn++;
    end
    chk("t3_pixels", 32'(k), 4);
    chk("t3_count", 32'(pixel_count), 4);
    chk("t3_done_pulses", 32'(dn), 1);
    win(12'd1, 12'd1, 8'd1, 8'd2, 8'd3, 8'd4); tick;
    in_valid = 1'b0; tick;
    chk("t3_idle_after_done", 32'(out_valid), 0);

    // Test 5: reset mid-frame with windows in flight
    decimate = 1'b0; bayer_phase = 2'b00;
    win(12'd0, 12'd0, 8'd0, 8'd0, 8'd0, 8'd0); tick;
    win(12'd1, 12'd1, 8'd10, 8'd200, 8'd50, 8'd30); tick;
    win(12'd2, 12'd1, 8'd10, 8'd200, 8'd50, 8'd30); reset = 1'b1; tick;
    reset = 1'b0; in_valid = 1'b0;
    chk("t5_valid0", 32'(out_valid), 0);
    chk("t5_count", 32'(pixel_count), 0);
    tick;
    chk("t5_valid1", 32'(out_valid), 0);
    tick;
    chk("t5_valid2", 32'(out_valid), 0);
    chk("t5_done", 32'(out_done), 0);
    win(12'd1, 12'd1, 8'd10, 8'd200, 8'd50, 8'd30); tick;
    in_valid = 1'b0; tick;
    chk("t5_resync_drop", 32'(out_valid), 0);

    // Resume after a new origin; also exercises gray output values
    win(12'd0, 12'd0, 8'd0, 8'd0, 8'd0, 8'd0); tick;
    win(12'd1, 12'd1, 8'd60, 8'd100, 8'd20, 8'd60); tick;
    win(12'd3, 12'd3, 8'd255, 8'd255, 8'd255, 8'd255); tick;
    chk("t6_valid", 32'(out_valid), 1);
    chk("t6_red", 32'(out_red), 100);
    chk("t6_green", 32'(out_green), 60);
    chk("t6_blue", 32'(out_blue), 20);
`ifdef GRAY_OUT_EN
    chk("t6_gray", 32'(out_gray), 60);
`endif
    in_valid = 1'b0; tick;
    chk("t6b_valid", 32'(out_valid), 1);
    chk("t6b_red", 32'(out_red), 255);
    chk("t6b_green", 32'(out_green), 255);
    chk("t6b_x", 32'(out_x), 2);
    chk("t6b_y", 32'(out_y), 2);
`ifdef GRAY_OUT_EN
    chk("t6b_gray", 32'(out_gray), 255);
`endif
    chk("t6_count", 32'(pixel_count), 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
